// File: rtl/hyperbus_phy2r.sv
// HyperBus PHY read words -> AXI R beats: packs words into wide beats, splits words into narrow beats.
// Optional HYPERBUS_PHY2R_ZERO_LANES_EN: zero r_data_o bytes outside the active beat lanes.
module hyperbus_phy2r #(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned NumPhys      = 2,
  parameter int unsigned BurstLength  = 8,
  parameter int unsigned AddrWidth    = $clog2(AxiDataWidth/8)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      trans_handshake_i,
  input  logic                      is_a_write_i,
  input  logic [2:0]                size_i,
  input  logic [AddrWidth-1:0]      start_addr_i,
  input  logic [BurstLength-1:0]    len_i,
  input  logic                      phy_valid_i,
  output logic                      phy_ready_o,
  input  logic [16*NumPhys-1:0]     phy_data_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [AxiDataWidth-1:0]   r_data_o,
  output logic                      r_last_o,
  output logic                      busy_o
);
  localparam int unsigned PhyBytes = 2*NumPhys;
  localparam int unsigned AxiBytes = AxiDataWidth/8;
  localparam int unsigned MaxSize  = $clog2(AxiBytes);
  localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(PhyBytes-1);

  typedef enum logic [1:0] {Idle, Fill, Drain} state_e;

  state_e                         state_q;
  logic [AxiBytes-1:0][7:0]       buffer_q;
  logic [AddrWidth-1:0]           byte_idx_q;
  logic [BurstLength-1:0]         beat_cnt_q, len_q;
  logic [2:0]                     size_q;

  logic [AddrWidth:0]   bsz, beat_base, beat_end, word_nxt;
  logic [AddrWidth-1:0] word_off, drain_nxt;
  logic [2:0]           size_clamp;
  logic                 last, rd_start, fill_done, drain_stay, take;

  assign bsz        = (AddrWidth+1)'(1) << size_q;
  assign beat_base  = ({1'b0, byte_idx_q} >> size_q) << size_q;
  assign beat_end   = beat_base + bsz;
  assign word_off   = byte_idx_q & ~OffMask;
  assign word_nxt   = {1'b0, word_off} + (AddrWidth+1)'(PhyBytes);
  // Wraps modulo AxiBytes by truncation
  assign drain_nxt  = beat_base[AddrWidth-1:0] + bsz[AddrWidth-1:0];
  assign size_clamp = (size_i > 3'(MaxSize)) ? 3'(MaxSize) : size_i;
  assign last       = (beat_cnt_q == len_q);
  assign rd_start   = trans_handshake_i & ~is_a_write_i;
  assign fill_done  = (bsz <= (AddrWidth+1)'(PhyBytes)) ||
                      (word_nxt[AddrWidth-1:0] == beat_end[AddrWidth-1:0]);
  assign drain_stay = (bsz < (AddrWidth+1)'(PhyBytes)) && ((drain_nxt & OffMask) != '0);
  // New read accepted only when idle or as the final beat leaves
  assign take       = rd_start && ((state_q == Idle) ||
                                   (state_q == Drain && r_ready_i && last));

`ifdef HYPERBUS_PHY2R_ZERO_LANES_EN
  // Byte index at the start of the current beat (byte_idx_q advances during wide fills)
  logic [AddrWidth-1:0] lane_lo_q;
  logic [AddrWidth:0]   lo_end;
  assign lo_end = ((({1'b0, lane_lo_q}) >> size_q) << size_q) + bsz;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      buffer_q   <= '0;
      byte_idx_q <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      size_q     <= '0;
`ifdef HYPERBUS_PHY2R_ZERO_LANES_EN
      lane_lo_q  <= '0;
`endif
    end else begin
      case (state_q)
        Fill: if (phy_valid_i) begin
          for (int i = 0; i < PhyBytes; i++)
            buffer_q[word_off + AddrWidth'(i)] <= phy_data_i[8*i +: 8];
          if (fill_done) state_q    <= Drain;
          else           byte_idx_q <= word_nxt[AddrWidth-1:0];
        end
        Drain: if (r_ready_i) begin
          byte_idx_q <= drain_nxt;
          beat_cnt_q <= beat_cnt_q + BurstLength'(1);
`ifdef HYPERBUS_PHY2R_ZERO_LANES_EN
          lane_lo_q  <= drain_nxt;
          if (last) buffer_q <= '0;
`endif
          if (last)            state_q <= Idle;
          else if (drain_stay) state_q <= Drain;
          else                 state_q <= Fill;
        end
        default: ;
      endcase
      if (take) begin
        size_q     <= size_clamp;
        len_q      <= len_i;
        byte_idx_q <= start_addr_i;
        beat_cnt_q <= '0;
        state_q    <= Fill;
`ifdef HYPERBUS_PHY2R_ZERO_LANES_EN
        lane_lo_q  <= start_addr_i;
`endif
      end
    end
  end

  assign phy_ready_o = (state_q == Fill);
  assign r_valid_o   = (state_q == Drain);
  assign r_last_o    = r_valid_o & last;
  assign busy_o      = (state_q != Idle);

  always_comb begin
    r_data_o = '0;
    if (r_valid_o) begin
      for (int l = 0; l < AxiBytes; l++) begin
`ifdef HYPERBUS_PHY2R_ZERO_LANES_EN
        if ((AddrWidth+1)'(l) >= {1'b0, lane_lo_q} && (AddrWidth+1)'(l) < lo_end)
          r_data_o[8*l +: 8] = buffer_q[l];
`else
        r_data_o[8*l +: 8] = buffer_q[l];
`endif
      end
    end
  end
endmodule
